// File: rtl/fir_pkg.sv
// Shared constants, FSM state type and output rounding for the serial FIR MAC.
// Optional macro SERIAL_FIR_SAT_EN: saturate the output (otherwise wrap).
package fir_pkg;

  localparam int unsigned TAPS      = 32;
  localparam int unsigned AW        = 5;
  localparam int unsigned DW        = 16;
  localparam int unsigned CW        = 16;
  localparam int unsigned ACCW      = 37;
  localparam int unsigned OUT_SHIFT = 15;

  localparam logic signed [ACCW-1:0] RND_HALF = ACCW'(2 ** (OUT_SHIFT - 1));
  localparam logic signed [ACCW-1:0] SAT_MAX  = ACCW'((2 ** (DW - 1)) - 1);
  localparam logic signed [ACCW-1:0] SAT_MIN  = -ACCW'(2 ** (DW - 1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } fir_state_t;

  // Round-half-up, arithmetic shift, then clamp or wrap to DW bits
  function automatic logic signed [DW-1:0] round_sat(input logic signed [ACCW-1:0] acc);
    logic signed [ACCW-1:0] r;
    logic signed [DW-1:0]   res;
    r = $signed(acc + RND_HALF) >>> OUT_SHIFT;
`ifdef SERIAL_FIR_SAT_EN
    if (r > SAT_MAX) begin
      res = SAT_MAX[DW-1:0];
    end else if (r < SAT_MIN) begin
      res = SAT_MIN[DW-1:0];
    end else begin
      res = DW'(r);
    end
`else
    res = DW'(r);
`endif
    return res;
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// TAPS x DW sample history: one synchronous write port, one combinational read port.
module fir_delay_line
  import fir_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_we,
  input  logic [AW-1:0]        i_wr_ptr,
  input  logic signed [DW-1:0] i_wr_data,
  input  logic [AW-1:0]        i_rd_idx,
  output logic signed [DW-1:0] o_rd_data_c
);

  logic signed [DW-1:0] r_line [TAPS];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < TAPS; i++) begin
        r_line[i] <= '0;
      end
    end else if (i_we) begin
      r_line[i_wr_ptr] <= i_wr_data;
    end
  end

  assign o_rd_data_c = r_line[i_rd_idx];

endmodule

// File: rtl/serial_fir_mac.sv
// Time-multiplexed 32-tap FIR: one MAC per clock against an external combinational ROM.
// Optional macro SERIAL_FIR_SAT_EN selects output saturation instead of wrap.
module serial_fir_mac
  import fir_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  output logic                 in_ready,
  output logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_data,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_data
);

  fir_state_t                 r_state;
  fir_state_t                 w_state_nxt;
  logic [AW-1:0]              r_k;
  logic [AW-1:0]              r_wr_ptr;
  logic signed [ACCW-1:0]     r_acc;
  logic                       r_in_ready;
  logic                       r_out_valid;
  logic signed [DW-1:0]       r_out_data;
  logic                       w_accept;
  logic                       w_mac_last;
  logic [AW-1:0]              w_rd_idx;
  logic signed [DW-1:0]       w_sample;
  logic signed [DW+CW-1:0]    w_prod;

  // Index subtraction wraps naturally because TAPS is a power of two
  assign w_rd_idx = r_wr_ptr - r_k;
  assign w_prod   = w_sample * coef_data;

  fir_delay_line u_line (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_we        (w_accept),
    .i_wr_ptr    (r_wr_ptr),
    .i_wr_data   (in_data),
    .i_rd_idx    (w_rd_idx),
    .o_rd_data_c (w_sample)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_mac_last  = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid && r_in_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = MAC;
        end
      end
      MAC: begin
        if (r_k == AW'(TAPS - 1)) begin
          w_mac_last  = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Accumulator, tap counter, write pointer and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k         <= '0;
      r_wr_ptr    <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (r_state == DONE);
      if (r_state == DONE) begin
        r_out_data <= round_sat(r_acc);
      end
      if (w_accept) begin
        r_acc <= '0;
        r_k   <= '0;
      end else if (r_state == MAC) begin
        r_acc <= r_acc + ACCW'(w_prod);
        r_k   <= r_k + AW'(1);
      end
      if (w_mac_last) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign coef_addr = r_k;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_serial_fir_mac.sv
// Randomized scoreboard bench for serial_fir_mac against a direct-form FIR reference.
module tb_serial_fir_mac;
  import fir_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic signed [15:0]   in_data;
  logic                 in_ready;
  logic [4:0]           coef_addr;
  logic signed [15:0]   coef_data;
  logic                 out_valid;
  logic signed [15:0]   out_data;

  logic signed [15:0]   rom [32];
  int                   checks = 0;
  int                   errors = 0;
  logic signed [15:0]   exp_q [$];
  int                   hist [$];
  logic signed [15:0]   last_out;
  logic signed [15:0]   mon_exp;
  int                   n_out = 0;

  always #5 clk = ~clk;

  assign coef_data = rom[coef_addr];

  serial_fir_mac dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // y[n] = sum_k h[k]*x[n-k] over the whole history since reset, then round
  function automatic logic signed [15:0] model();
    longint acc = 0;
    longint r;
    int n = hist.size() - 1;
    for (int k = 0; k < 32; k++) begin
      if (n - k >= 0) acc += longint'(hist[n - k]) * longint'(rom[k]);
    end
    r = (acc + 64'sd16384) >>> 15;
`ifdef SERIAL_FIR_SAT_EN
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`endif
    return 16'(r);
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      last_out = out_data;
      n_out++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual=%0d required=none", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_data", out_data, mon_exp);
      end
    end
  end

  task automatic send(input logic signed [15:0] x, input bit timing);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    in_data  = x;
    @(posedge clk);
    hist.push_back(int'(x));
    exp_q.push_back(model());
    if (timing) begin
      for (int j = 0; j <= 32; j++) begin
        @(negedge clk);
        in_valid = (j < 32);
        in_data  = 16'sh1234;
        check("in_ready_busy", in_ready, 0);
        check("out_valid_early", out_valid, 0);
        if (j <= 31) check("coef_addr", coef_addr, j);
      end
      @(negedge clk);
      check("out_valid_pulse", out_valid, 1);
      check("in_ready_back", in_ready, 1);
      @(negedge clk);
      check("out_valid_once", out_valid, 0);
    end else begin
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || !in_ready) && g < 300) begin
      @(negedge clk);
      g++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_coef_addr", coef_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    hist.delete();
    exp_q.delete();
    rst = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n_before;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    for (int k = 0; k < 32; k++) rom[k] = 16'($urandom);
    do_reset();

    // Impulse through a random symmetric ROM, first sample with cycle-level checks
    for (int k = 0; k < 16; k++) begin
      rom[k]      = 16'($urandom);
      rom[31 - k] = rom[k];
    end
    send(16'sd32767, 1'b1);
    for (int i = 0; i < 31; i++) send(16'sd0, 1'b0);
    drain();

    // Full-scale DC into full-scale ROM: saturates or wraps
    for (int k = 0; k < 32; k++) rom[k] = 16'sh7FFF;
    for (int i = 0; i < 32; i++) send(16'sd32767, 1'b0);
    drain();
`ifdef SERIAL_FIR_SAT_EN
    check("dc_32nd", last_out, 32767);
`else
    check("dc_32nd", last_out, -64);
`endif

    // Negative rounding: -3 * 0x4000 rounds to -1
    do_reset();
    for (int k = 0; k < 32; k++) rom[k] = 16'sd0;
    rom[0] = 16'sh4000;
    send(-16'sd3, 1'b0);
    drain();
    check("neg_round", last_out, -1);

    // Ramp beyond 32 samples exercises pointer wrap, then random data
    for (int k = 0; k < 32; k++) rom[k] = 16'($urandom);
    for (int i = 1; i <= 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(16'(i), 1'b0);
    end
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(16'($urandom), 1'b0);
    end
    drain();

    // Reset during MAC must suppress the pulse and clear history
    send(16'sd12345, 1'b0);
    repeat (9) @(posedge clk);
    n_before = n_out;
    #1;
    do_reset();
    repeat (40) @(negedge clk);
    check("no_pulse_after_abort", n_out, n_before);
    for (int k = 0; k < 32; k++) rom[k] = 16'($urandom);
    rom[0] = -16'sd33;
    send(16'sd32767, 1'b0);
    drain();
    check("post_reset_impulse", last_out, -33);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
